execute_cc_mreg: RTL and testbench

// Downstream of the 64-bit ALU in the Y86-64 execute stage. Derives ZF/SF/OF from the ALU

---
 rtl/execute_cc_mreg.sv | 135 +++++++++++++
 tb/tb_execute_cc_mreg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_mreg.sv
// Y86-64 execute-stage back end: derives ZF/SF/OF, holds the condition codes,
// evaluates the branch/cmov condition and registers the E->M pipeline stage.
module execute_cc_mreg #(
    parameter int unsigned WIDTH  = 64,
    parameter logic [2:0]  CC_RST = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       e_stat,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [WIDTH-1:0] e_valA,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             set_cc,
    input  logic             m_stall,
    input  logic             m_bubble,
    output logic             e_cnd,
    output logic [3:0]       e_dstE_o,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic [3:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    localparam logic [3:0] STAT_AOK   = 4'h1;
    localparam logic [3:0] ICODE_NOP  = 4'h1;
    localparam logic [3:0] ICODE_CMOV = 4'h2;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] RNONE      = 4'hF;

    logic [2:0] cc_q, cc_d;
    logic       zf_new, sf_new, of_new;
    logic       a_neg, b_neg, r_neg, lt;

    logic [3:0]       m_stat_q, m_icode_q, m_dstE_q, m_dstM_q;
    logic             m_cnd_q;
    logic [WIDTH-1:0] m_valE_q, m_valA_q;

    // Only the operand sign bits matter for overflow detection.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};

    assign a_neg = alu_a[WIDTH-1];
    assign b_neg = alu_b[WIDTH-1];
    assign r_neg = alu_res[WIDTH-1];

    // Fresh flags from the ALU operands/result; sub computes B-A.
    always_comb begin
        zf_new = (alu_res == '0);
        sf_new = r_neg;
        of_new = 1'b0;
        case (e_ifun)
            4'h0:    of_new = (a_neg == b_neg) && (r_neg != a_neg);
            4'h1:    of_new = (a_neg != b_neg) && (r_neg != b_neg);
            default: of_new = 1'b0;
        endcase
    end

    always_comb begin
        cc_d = cc_q;
        if (set_cc && (e_icode == ICODE_OPQ)) begin
            cc_d = {zf_new, sf_new, of_new};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= CC_RST;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    // Condition evaluated from the registered (pre-update) flags.
    assign lt = cc_q[1] ^ cc_q[0];
    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = lt | cc_q[2];
            4'h2:    e_cnd = lt;
            4'h3:    e_cnd = cc_q[2];
            4'h4:    e_cnd = ~cc_q[2];
            4'h5:    e_cnd = ~lt;
            4'h6:    e_cnd = ~lt & ~cc_q[2];
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_dstE_o = ((e_icode == ICODE_CMOV) && !e_cnd) ? RNONE : e_dstE;

    // M register: reset > bubble > stall > load.
    always_ff @(posedge clk) begin
        if (!rst_n || m_bubble) begin
            m_stat_q  <= STAT_AOK;
            m_icode_q <= ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_valE_q  <= '0;
            m_valA_q  <= '0;
            m_dstE_q  <= RNONE;
            m_dstM_q  <= RNONE;
        end else if (!m_stall) begin
            m_stat_q  <= e_stat;
            m_icode_q <= e_icode;
            m_cnd_q   <= e_cnd;
            m_valE_q  <= alu_res;
            m_valA_q  <= e_valA;
            m_dstE_q  <= e_dstE_o;
            m_dstM_q  <= e_dstM;
        end
    end

    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_valE_q;
    assign M_valA  = m_valA_q;
    assign M_dstE  = m_dstE_q;
    assign M_dstM  = m_dstM_q;

endmodule

// File: tb/tb_execute_cc_mreg.sv
// Bench for execute_cc_mreg: directed spec scenarios followed by randomized
// traffic checked against a flag/condition reference model.
module tb_execute_cc_mreg;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINNEG = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   e_stat, e_icode, e_ifun, e_dstE, e_dstM;
    logic [W-1:0] alu_a, alu_b, alu_res, e_valA;
    logic         set_cc, m_stall, m_bubble;
    logic         e_cnd, zf, sf, of, M_cnd;
    logic [3:0]   e_dstE_o, M_stat, M_icode, M_dstE, M_dstM;
    logic [W-1:0] M_valE, M_valA;

    always #5 clk = ~clk;

    execute_cc_mreg #(.WIDTH(W), .CC_RST(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .set_cc(set_cc), .m_stall(m_stall),
        .m_bubble(m_bubble), .e_cnd(e_cnd), .e_dstE_o(e_dstE_o), .zf(zf), .sf(sf), .of(of),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    // Reference state
    logic         mzf, msf, mof;
    logic [3:0]   mstat, micode, mdstE, mdstM;
    logic         mcnd;
    logic [W-1:0] mvalE, mvalA;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_neg(input logic [W-1:0] v);
        return $signed(v) < 0;
    endfunction

    // Signed "less than" is SF xor OF; the jump/cmov table is built on it.
    function automatic logic cond_ref(input logic [3:0] fn, input logic z, input logic s, input logic o);
        logic less;
        less = (s != o);
        case (fn)
            4'd0: return 1'b1;
            4'd1: return less || z;
            4'd2: return less;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !less;
            4'd6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic of_ref(input logic [3:0] fn, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [W-1:0] r);
        if (fn == 4'd0) return (is_neg(a) == is_neg(b)) && (is_neg(r) != is_neg(a));
        if (fn == 4'd1) return (is_neg(a) != is_neg(b)) && (is_neg(r) != is_neg(b));
        return 1'b0;
    endfunction

    // One cycle: check combinational outputs, advance model, check registered state.
    task automatic tick(input bit check_comb);
        logic         c;
        logic [3:0]   de;
        logic         nz, ns, no;
        #1;
        c  = cond_ref(e_ifun, mzf, msf, mof);
        de = (e_icode == 4'd2 && !c) ? 4'hF : e_dstE;
        if (check_comb) begin
            chk("e_cnd", {63'd0, e_cnd}, {63'd0, c});
            chk("e_dstE_o", {60'd0, e_dstE_o}, {60'd0, de});
        end
        nz = (alu_res == 0);
        ns = is_neg(alu_res);
        no = of_ref(e_ifun, alu_a, alu_b, alu_res);
        @(posedge clk);
        if (!rst_n) begin
            {mzf, msf, mof} = 3'b100;
        end else if (set_cc && e_icode == 4'd6) begin
            {mzf, msf, mof} = {nz, ns, no};
        end
        if (!rst_n || m_bubble) begin
            mstat = 4'd1; micode = 4'd1; mcnd = 1'b0; mvalE = '0; mvalA = '0;
            mdstE = 4'hF; mdstM = 4'hF;
        end else if (!m_stall) begin
            mstat = e_stat; micode = e_icode; mcnd = c; mvalE = alu_res; mvalA = e_valA;
            mdstE = de; mdstM = e_dstM;
        end
        #1;
        chk("cc", {61'd0, zf, sf, of}, {61'd0, mzf, msf, mof});
        chk("M_stat", {60'd0, M_stat}, {60'd0, mstat});
        chk("M_icode", {60'd0, M_icode}, {60'd0, micode});
        chk("M_cnd", {63'd0, M_cnd}, {63'd0, mcnd});
        chk("M_valE", M_valE, mvalE);
        chk("M_valA", M_valA, mvalA);
        chk("M_dstE", {60'd0, M_dstE}, {60'd0, mdstE});
        chk("M_dstM", {60'd0, M_dstM}, {60'd0, mdstM});
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r, input logic sc);
        e_icode = ic; e_ifun = fn; alu_a = a; alu_b = b; alu_res = r; set_cc = sc;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 64'd1;
            2: return MAXPOS;
            3: return MINNEG;
            4: return '1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [W-1:0] a, b, r;
        logic [3:0]   ic, fn;
        logic [3:0]   icodes [5];
        icodes[0] = 4'd1; icodes[1] = 4'd2; icodes[2] = 4'd6; icodes[3] = 4'd7; icodes[4] = 4'd6;

        // 1: reset with CC write requested still loads CC_RST and a NOP
        rst_n = 1'b0; e_stat = 4'd1; e_dstE = 4'd2; e_dstM = 4'd3; e_valA = 64'h55;
        m_stall = 1'b0; m_bubble = 1'b0;
        drive(4'd6, 4'd0, 64'd1, 64'd2, 64'd3, 1'b1);
        tick(1'b0);
        chk("t1_cc", {61'd0, zf, sf, of}, 64'd4);
        chk("t1_M_icode", {60'd0, M_icode}, 64'd1);
        chk("t1_M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("t1_M_valE", M_valE, 64'd0);
        rst_n = 1'b1;

        // 2: positive overflow on add
        drive(4'd6, 4'd0, 64'd1, MAXPOS, MINNEG, 1'b1);
        tick(1'b1);
        chk("t2_cc", {61'd0, zf, sf, of}, 64'd3);
        chk("t2_M_valE", M_valE, MINNEG);

        // 3: equal subtract, then cmov le taken and cmov g not taken
        drive(4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 1'b1);
        tick(1'b1);
        chk("t3_cc", {61'd0, zf, sf, of}, 64'd4);
        e_dstE = 4'd3;
        drive(4'd2, 4'd1, 64'd0, 64'd0, 64'd9, 1'b1);
        tick(1'b1);
        chk("t3_M_dstE_le", {60'd0, M_dstE}, 64'd3);
        drive(4'd2, 4'd6, 64'd0, 64'd0, 64'd9, 1'b1);
        #1;
        chk("t3_e_cnd_g", {63'd0, e_cnd}, 64'd0);
        tick(1'b1);
        chk("t3_M_dstE_g", {60'd0, M_dstE}, 64'hF);

        // 4: CC gated by set_cc; xor result zero sets ZF
        drive(4'd6, 4'd0, 64'd1, 64'd1, 64'd2, 1'b1);
        tick(1'b1);
        drive(4'd6, 4'd0, 64'd1, '1, 64'd0, 1'b0);
        tick(1'b1);
        chk("t4_zf_hold", {63'd0, zf}, 64'd0);
        drive(4'd6, 4'd3, 64'd7, 64'd7, 64'd0, 1'b1);
        tick(1'b1);
        chk("t4_xor_cc", {61'd0, zf, sf, of}, 64'd4);

        // 5: stall holds M; stall+bubble inserts a NOP
        m_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_valA = 64'h100 + 64'(i); e_dstM = 4'(i + 5);
            drive(4'd6, 4'd0, 64'd3, 64'd4, 64'd7, 1'b0);
            tick(1'b1);
            chk("t5_stall_valE", M_valE, 64'd0);
        end
        m_bubble = 1'b1;
        tick(1'b1);
        chk("t5_bub_icode", {60'd0, M_icode}, 64'd1);
        chk("t5_bub_dstE", {60'd0, M_dstE}, 64'hF);
        m_stall = 1'b0; m_bubble = 1'b0;

        // 6: jl with SF=OF=1 not taken; SF=1 OF=0 taken
        drive(4'd6, 4'd0, 64'd1, MAXPOS, MINNEG, 1'b1);
        tick(1'b1);
        drive(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1'b0);
        #1;
        chk("t6_jl_nt", {63'd0, e_cnd}, 64'd0);
        tick(1'b1);
        drive(4'd6, 4'd1, 64'd1, 64'd0, '1, 1'b1);
        tick(1'b1);
        drive(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1'b0);
        #1;
        chk("t6_jl_t", {63'd0, e_cnd}, 64'd1);
        tick(1'b1);
        chk("t6_M_cnd", {63'd0, M_cnd}, 64'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            a = pick_operand(); b = pick_operand();
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : icodes[$urandom_range(0, 4)];
            fn = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : 4'($urandom_range(0, 6));
            case (fn)
                4'd0:    r = a + b;
                4'd1:    r = b - a;
                4'd3:    r = a ^ b;
                default: r = a & b;
            endcase
            if ($urandom_range(0, 7) == 0) r = pick_operand();
            rst_n    = ($urandom_range(0, 49) != 0);
            m_stall  = ($urandom_range(0, 7) == 0);
            m_bubble = ($urandom_range(0, 9) == 0);
            e_stat   = 4'($urandom_range(1, 4));
            e_dstE   = 4'($urandom());
            e_dstM   = 4'($urandom());
            e_valA   = {$urandom(), $urandom()};
            drive(ic, fn, a, b, r, ($urandom_range(0, 3) != 0));
            tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
